// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle type, its bubble value and default widths for the
// ID/EX, EX/MEM and MEM/WB control pipeline registers.
package pipe_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int ALUOP_W       = 4;
    localparam int BE_W          = 4;
    localparam int RWSRC_W       = 2;

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic               alu_src_b;
        logic [BE_W-1:0]    d_mem_be;
        logic               d_mem_wen;   // active-low write enable
        logic               mem_read;
        logic               iord;
        logic [RWSRC_W-1:0] rw_src;
        logic               rf_we;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        valid:     1'b0,
        alu_op:    '0,
        alu_src_a: 1'b0,
        alu_src_b: 1'b0,
        d_mem_be:  '0,
        d_mem_wen: 1'b1,
        mem_read:  1'b0,
        iord:      1'b0,
        rw_src:    '0,
        rf_we:     1'b0
    };

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One control-bundle pipeline register: async reset to bubble, hold when
// en=0, and load either the bubble or the incoming bundle when en=1.
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             load_bubble,
    input  ctrl_t            d,
    input  logic [REG_W-1:0] d_rd,
    output ctrl_t            q,
    output logic [REG_W-1:0] q_rd
);

    ctrl_t            r_q;
    logic [REG_W-1:0] r_rd;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, which is what makes a pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q  <= BUBBLE;
            r_rd <= '0;
        end else if (en) begin
            if (load_bubble) begin
                r_q  <= BUBBLE;
                r_rd <= '0;
            end else begin
                r_q  <= d;
                r_rd <= d_rd;
            end
        end
    end

    assign q    = r_q;
    assign q_rd = r_rd;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Control pipeline from ID through WB: load-use stall detection, bubble
// injection on stall/flush, and the retired-instruction counter.
module pipe_ctrl_regs
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pipe_en,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       id_ALUOp,
    input  logic             id_ALUSrcA,
    input  logic             id_ALUSrcB,
    input  logic [3:0]       id_D_MEM_BE,
    input  logic             id_D_MEM_WEN,
    input  logic             id_MemRead,
    input  logic             id_IorD,
    input  logic [1:0]       id_RWSrc,
    input  logic             id_RF_WE,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             stall,
    output logic             ex_valid,
    output logic [3:0]       ex_ALUOp,
    output logic             ex_ALUSrcA,
    output logic             ex_ALUSrcB,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_valid,
    output logic [3:0]       mem_D_MEM_BE,
    output logic             mem_D_MEM_WEN,
    output logic             mem_MemRead,
    output logic             mem_IorD,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_valid,
    output logic [1:0]       wb_RWSrc,
    output logic             wb_RF_WE,
    output logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] num_inst
);

    ctrl_t            w_id, w_ex, w_mem, w_wb;
    logic [REG_W-1:0] w_id_rd, w_ex_rd, w_mem_rd, w_wb_rd;
    logic             w_rs1_hit, w_rs2_hit, w_hz, w_id_bubble;
    logic [CNT_W-1:0] r_num_inst;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_id    = BUBBLE;
        w_id_rd = '0;
        if (id_valid) begin
            w_id.valid     = 1'b1;
            w_id.alu_op    = id_ALUOp;
            w_id.alu_src_a = id_ALUSrcA;
            w_id.alu_src_b = id_ALUSrcB;
            w_id.d_mem_be  = id_D_MEM_BE;
            w_id.d_mem_wen = id_D_MEM_WEN;
            w_id.mem_read  = id_MemRead;
            w_id.iord      = id_IorD;
            w_id.rw_src    = id_RWSrc;
            w_id.rf_we     = id_RF_WE;
            w_id_rd        = id_rd;
        end
    end

    assign w_rs1_hit   = id_use_rs1 && (id_rs1 == w_ex_rd);
    assign w_rs2_hit   = id_use_rs2 && (id_rs2 == w_ex_rd);
    assign w_hz        = id_valid && w_ex.valid && w_ex.mem_read &&
                         (w_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
    assign stall       = w_hz && !flush && !RST;
    assign w_id_bubble = flush || w_hz;

    pipe_ctrl_stage #(.REG_W(REG_W)) u_id_ex (
        .CLK(CLK), .RST(RST), .en(pipe_en), .load_bubble(w_id_bubble),
        .d(w_id), .d_rd(w_id_rd), .q(w_ex), .q_rd(w_ex_rd)
    );

    pipe_ctrl_stage #(.REG_W(REG_W)) u_ex_mem (
        .CLK(CLK), .RST(RST), .en(pipe_en), .load_bubble(1'b0),
        .d(w_ex), .d_rd(w_ex_rd), .q(w_mem), .q_rd(w_mem_rd)
    );

    pipe_ctrl_stage #(.REG_W(REG_W)) u_mem_wb (
        .CLK(CLK), .RST(RST), .en(pipe_en), .load_bubble(1'b0),
        .d(w_mem), .d_rd(w_mem_rd), .q(w_wb), .q_rd(w_wb_rd)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_num_inst <= '0;
        end else if (pipe_en && w_wb.valid) begin
            r_num_inst <= r_num_inst + 1'b1;
        end
    end

    assign ex_valid      = w_ex.valid;
    assign ex_ALUOp      = w_ex.alu_op;
    assign ex_ALUSrcA    = w_ex.alu_src_a;
    assign ex_ALUSrcB    = w_ex.alu_src_b;
    assign ex_rd         = w_ex_rd;
    assign mem_valid     = w_mem.valid;
    assign mem_D_MEM_BE  = w_mem.d_mem_be;
    assign mem_D_MEM_WEN = w_mem.d_mem_wen;
    assign mem_MemRead   = w_mem.mem_read;
    assign mem_IorD      = w_mem.iord;
    assign mem_rd        = w_mem_rd;
    assign wb_valid      = w_wb.valid;
    assign wb_RWSrc      = w_wb.rw_src;
    assign wb_RF_WE      = w_wb.rf_we;
    assign wb_rd         = w_wb_rd;
    assign num_inst      = r_num_inst;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs with a WB-side scoreboard and a small
// reference model of EX occupancy, stage validity and the retire count.
module tb_pipe_ctrl_regs;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             pipe_en, flush, id_valid;
    logic [3:0]       id_ALUOp, id_D_MEM_BE;
    logic             id_ALUSrcA, id_ALUSrcB, id_D_MEM_WEN, id_MemRead, id_IorD, id_RF_WE;
    logic [1:0]       id_RWSrc;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             stall;
    logic             ex_valid, ex_ALUSrcA, ex_ALUSrcB;
    logic [3:0]       ex_ALUOp;
    logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
    logic             mem_valid, mem_D_MEM_WEN, mem_MemRead, mem_IorD;
    logic [3:0]       mem_D_MEM_BE;
    logic             wb_valid, wb_RF_WE;
    logic [1:0]       wb_RWSrc;
    logic [CNT_W-1:0] num_inst;

    typedef struct {
        logic [REG_W-1:0] rd;
        logic             rf_we;
        logic [1:0]       rw_src;
    } sb_t;

    sb_t              sb_q[$];
    int               checks = 0;
    int               errors = 0;
    logic             m_ex_valid, m_ex_mr, m_mem_valid, m_wb_valid;
    logic [REG_W-1:0] m_ex_rd;
    logic [CNT_W-1:0] m_num;

    pipe_ctrl_regs #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
        .id_ALUOp(id_ALUOp), .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB),
        .id_D_MEM_BE(id_D_MEM_BE), .id_D_MEM_WEN(id_D_MEM_WEN), .id_MemRead(id_MemRead),
        .id_IorD(id_IorD), .id_RWSrc(id_RWSrc), .id_RF_WE(id_RF_WE),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .stall(stall),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_ALUSrcA(ex_ALUSrcA),
        .ex_ALUSrcB(ex_ALUSrcB), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_D_MEM_BE(mem_D_MEM_BE), .mem_D_MEM_WEN(mem_D_MEM_WEN),
        .mem_MemRead(mem_MemRead), .mem_IorD(mem_IorD), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_RWSrc(wb_RWSrc), .wb_RF_WE(wb_RF_WE), .wb_rd(wb_rd),
        .num_inst(num_inst)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads read memory and write back from it; ALU ops write back the ALU result.
    task automatic set_id(input logic v, input logic [3:0] op, input logic mr,
                          input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                          input logic [REG_W-1:0] rs2, input logic u1, input logic u2);
        id_valid     = v;
        id_ALUOp     = op;
        id_ALUSrcA   = 1'b0;
        id_ALUSrcB   = mr;
        id_D_MEM_BE  = mr ? 4'hF : 4'h0;
        id_D_MEM_WEN = 1'b1;
        id_MemRead   = mr;
        id_IorD      = mr;
        id_RWSrc     = mr ? 2'b01 : 2'b00;
        id_RF_WE     = v;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
    endtask

    task automatic idle();
        set_id(1'b0, 4'h0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        m_ex_valid  = 1'b0;
        m_ex_mr     = 1'b0;
        m_ex_rd     = '0;
        m_mem_valid = 1'b0;
        m_wb_valid  = 1'b0;
        m_num       = '0;
        sb_q.delete();
    endtask

    // One clock: check stall before the edge, advance the model, then check WB after it.
    task automatic tick();
        logic exp_hz;
        logic do_pop;
        sb_t  e;
        #1;
        exp_hz = id_valid & m_ex_valid & m_ex_mr & (m_ex_rd != '0) &
                 ((id_use_rs1 & (id_rs1 == m_ex_rd)) | (id_use_rs2 & (id_rs2 == m_ex_rd)));
        check("stall", 32'(stall), 32'(exp_hz & ~flush));
        do_pop = pipe_en & m_wb_valid;
        do_pop = 1'b0;
        if (pipe_en) begin
            if (m_wb_valid) m_num = m_num + 1'b1;
            m_wb_valid  = m_mem_valid;
            m_mem_valid = m_ex_valid;
            if (id_valid && !flush && !exp_hz) begin
                sb_q.push_back('{rd: id_rd, rf_we: id_RF_WE, rw_src: id_RWSrc});
                m_ex_valid = 1'b1;
                m_ex_mr    = id_MemRead;
                m_ex_rd    = id_rd;
            end else begin
                m_ex_valid = 1'b0;
                m_ex_mr    = 1'b0;
                m_ex_rd    = '0;
            end
            do_pop = m_wb_valid;
        end
        @(posedge CLK);
        #1;
        check("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
        check("num_inst", 32'(num_inst), 32'(m_num));
        if (do_pop) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_retire", 32'(wb_rd), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_RF_WE", 32'(wb_RF_WE), 32'(e.rf_we));
                check("wb_RWSrc", 32'(wb_RWSrc), 32'(e.rw_src));
            end
        end
    endtask

    initial begin
        pipe_en = 1'b1;
        flush   = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_mem_wen", 32'(mem_D_MEM_WEN), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_num_inst", 32'(num_inst), 32'd0);
        RST = 1'b0;

        // Three back-to-back ALU instructions.
        set_id(1'b1, 4'h2, 1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        check("ex_rd_c1", 32'(ex_rd), 32'd5);
        check("ex_ALUOp_c1", 32'(ex_ALUOp), 32'h2);
        set_id(1'b1, 4'h2, 1'b0, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        check("mem_rd_c2", 32'(mem_rd), 32'd5);
        set_id(1'b1, 4'h2, 1'b0, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        check("wb_rd_c3", 32'(wb_rd), 32'd5);
        check("wb_RF_WE_c3", 32'(wb_RF_WE), 32'd1);
        idle();
        repeat (3) tick();
        check("num_inst_three", 32'(num_inst), 32'd3);

        // Load-use on rs2: stall, bubble into EX, then the held instruction enters EX.
        set_id(1'b1, 4'h0, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'h2, 1'b0, 5'd9, 5'd1, 5'd8, 1'b0, 1'b1);
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        tick();
        check("lu_ex_valid", 32'(ex_valid), 32'd0);
        check("lu_ex_ALUOp", 32'(ex_ALUOp), 32'd0);
        check("lu_mem_wen", 32'(mem_D_MEM_WEN), 32'd1);
        check("lu_mem_read", 32'(mem_MemRead), 32'd1);
        tick();
        check("lu_ex_rd_after", 32'(ex_rd), 32'd9);

        // Load to x0 never stalls.
        set_id(1'b1, 4'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'h2, 1'b0, 5'd10, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        check("nostall_rd0", 32'(stall), 32'd0);
        tick();

        // Matching rs1 that is not actually read never stalls.
        set_id(1'b1, 4'h0, 1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'h2, 1'b0, 5'd12, 5'd11, 5'd3, 1'b0, 1'b1);
        #1;
        check("nostall_unused_rs1", 32'(stall), 32'd0);
        tick();

        // Flush wins over a simultaneous load-use hazard.
        set_id(1'b1, 4'h0, 1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'h2, 1'b0, 5'd14, 5'd13, 5'd0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_mem_read", 32'(mem_MemRead), 32'd1);
        check("flush_mem_rd", 32'(mem_rd), 32'd13);

        // Freeze for four cycles mid-stream, then resume.
        set_id(1'b1, 4'h3, 1'b0, 5'd20, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'h3, 1'b0, 5'd21, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        pipe_en = 1'b0;
        set_id(1'b1, 4'h3, 1'b0, 5'd22, 5'd1, 5'd2, 1'b1, 1'b1);
        repeat (4) tick();
        check("frz_ex_rd", 32'(ex_rd), 32'd21);
        check("frz_mem_rd", 32'(mem_rd), 32'd20);
        pipe_en = 1'b1;
        tick();
        check("resume_ex_rd", 32'(ex_rd), 32'd22);
        check("resume_mem_rd", 32'(mem_rd), 32'd21);
        check("resume_wb_rd", 32'(wb_rd), 32'd20);

        // Six more retires take the 4-bit count from 13 through 15 and wrap to 3.
        for (int i = 0; i < 6; i++) begin
            set_id(1'b1, 4'h1, 1'b0, 5'(24 + i), 5'd1, 5'd2, 1'b1, 1'b1);
            tick();
        end
        idle();
        repeat (4) tick();
        check("num_inst_wrap", 32'(num_inst), 32'd3);

        // Asynchronous reset between clock edges.
        set_id(1'b1, 4'h2, 1'b0, 5'd30, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'h2, 1'b0, 5'd31, 5'd1, 5'd2, 1'b1, 1'b1);
        tick();
        #3;
        RST = 1'b1;
        #1;
        check("arst_ex_valid", 32'(ex_valid), 32'd0);
        check("arst_ex_rd", 32'(ex_rd), 32'd0);
        check("arst_mem_valid", 32'(mem_valid), 32'd0);
        check("arst_mem_wen", 32'(mem_D_MEM_WEN), 32'd1);
        check("arst_wb_valid", 32'(wb_valid), 32'd0);
        check("arst_num_inst", 32'(num_inst), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        model_clear();
        RST = 1'b0;
        idle();
        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
